// File: rtl/pixel_window_pkg.sv
// Shared constants for the 3x3 pixel window: default pixel width, tap indices
// in row-major order and the helper that maps a tap to its bit position.
package pixel_window_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int SLICE_W   = PIX_W_DEF;
  localparam int TAPS      = 9;

  localparam int TL = 0;
  localparam int TC = 1;
  localparam int TR = 2;
  localparam int ML = 3;
  localparam int MC = 4;
  localparam int MR = 5;
  localparam int BL = 6;
  localparam int BC = 7;
  localparam int BR = 8;

  // Top-left occupies the most significant slice, bottom-right the least.
  function automatic int tap_lsb(input int tap, input int pix_w);
    return (TAPS - 1 - tap) * pix_w;
  endfunction

endpackage

// File: rtl/pixel_line_buffer.sv
// One image line of delay: combinational read and registered write at the same
// pointer, so a read returns the value stored one line earlier.
module pixel_line_buffer #(
  parameter int LINE_LEN = 64,
  parameter int PIX_W    = 8,
  localparam int PTR_W   = $clog2(LINE_LEN)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic [PIX_W-1:0] wr_data_i,
  output logic [PIX_W-1:0] rd_data_o
);

  logic [PIX_W-1:0] mem_q [LINE_LEN];

  assign rd_data_o = mem_q[ptr_i];

  // Storage is intentionally not reset; stale contents are refilled each line.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[ptr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/pixel_window.sv
// 3x3 sliding neighbourhood over a raster byte stream, built from two chained
// line buffers feeding the right-hand column of a shifting register array.
module pixel_window
  import pixel_window_pkg::*;
#(
  parameter int LINE_LEN = 64,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int ROW_W    = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        sof,
  input  logic [PIX_W-1:0]            pixel_in,
  output logic [9*PIX_W-1:0]          window,
  output logic                        win_valid,
  output logic [$clog2(LINE_LEN)-1:0] col,
  output logic [ROW_W-1:0]            row
);

  localparam int COL_W = $clog2(LINE_LEN);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = '1;

  logic [COL_W-1:0] ptr_q, ptr_d, col_q, cur_col;
  logic [ROW_W-1:0] rpos_q, rpos_d, row_q, cur_row;
  logic             vld_q, vld_d;
  logic [PIX_W-1:0] win_q [TAPS];
  logic [PIX_W-1:0] win_d [TAPS];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  pixel_line_buffer #(.LINE_LEN(LINE_LEN), .PIX_W(PIX_W)) u_lb0 (
    .clk_i     (clk),
    .en_i      (en),
    .ptr_i     (cur_col),
    .wr_data_i (pixel_in),
    .rd_data_o (lb0_rd)
  );

  pixel_line_buffer #(.LINE_LEN(LINE_LEN), .PIX_W(PIX_W)) u_lb1 (
    .clk_i     (clk),
    .en_i      (en),
    .ptr_i     (cur_col),
    .wr_data_i (lb0_rd),
    .rd_data_o (lb1_rd)
  );

  always_comb begin
    // sof makes the incoming pixel position (0,0) regardless of the counters.
    cur_col = sof ? '0 : ptr_q;
    cur_row = sof ? '0 : rpos_q;
    ptr_d   = cur_col + COL_W'(1);
    rpos_d  = cur_row;
    if (cur_col == COL_LAST) begin
      ptr_d  = '0;
      rpos_d = (cur_row == ROW_MAX) ? cur_row : cur_row + ROW_W'(1);
    end
    vld_d = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

    win_d[TL] = win_q[TC];
    win_d[TC] = win_q[TR];
    win_d[TR] = lb1_rd;
    win_d[ML] = win_q[MC];
    win_d[MC] = win_q[MR];
    win_d[MR] = lb0_rd;
    win_d[BL] = win_q[BC];
    win_d[BC] = win_q[BR];
    win_d[BR] = pixel_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      rpos_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      vld_q  <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      vld_q <= en & vld_d;
      if (en) begin
        ptr_q  <= ptr_d;
        rpos_q <= rpos_d;
        col_q  <= cur_col;
        row_q  <= cur_row;
        for (int k = 0; k < TAPS; k++) begin
          win_q[k] <= win_d[k];
        end
      end
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_taps
    localparam int LSB = tap_lsb(k, PIX_W);
    assign window[LSB +: PIX_W] = win_q[k];
  end

  assign win_valid = vld_q;
  assign col       = col_q;
  assign row       = row_q;

endmodule

// File: tb/tb_pixel_window.sv
// Self-checking bench for pixel_window: a frame-array reference model predicts
// position, valid strobe and neighbourhood for every accepted pixel.
module tb_pixel_window;

  localparam int LL   = 4;
  localparam int MAXR = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sof = 1'b0;
  logic [7:0]  pixel_in = '0;

  logic [71:0] w10, ws;
  logic        v10, vs;
  logic [1:0]  c10, cs;
  logic [9:0]  r10;
  logic [1:0]  rs;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0]  frame [MAXR][LL];
  int          nxt_r = 0, nxt_c = 0, cur_r = 0, cur_c = 0;
  logic        exp_vld;
  logic [71:0] exp_win;

  pixel_window #(.LINE_LEN(LL), .PIX_W(8), .ROW_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sof(sof), .pixel_in(pixel_in),
    .window(w10), .win_valid(v10), .col(c10), .row(r10)
  );

  pixel_window #(.LINE_LEN(LL), .PIX_W(8), .ROW_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .sof(sof), .pixel_in(pixel_in),
    .window(ws), .win_valid(vs), .col(cs), .row(rs)
  );

  always #10 clk = ~clk;

  function automatic logic [1:0] sat_row(input int r);
    return (r > 3) ? 2'd3 : 2'(r);
  endfunction

  // Drive one accepted pixel and update the model's expectations.
  task automatic send_pixel(input logic [7:0] p, input logic s);
    @(negedge clk);
    en = 1'b1; sof = s; pixel_in = p;
    @(posedge clk); #1;
    en = 1'b0; sof = 1'b0;
    if (s) begin nxt_r = 0; nxt_c = 0; end
    cur_r = nxt_r; cur_c = nxt_c;
    if (cur_r < MAXR) frame[cur_r][cur_c] = p;
    exp_vld = (cur_r >= 2) && (cur_c >= 2);
    exp_win = '0;
    if (exp_vld && cur_r < MAXR)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          exp_win[(8 - (i*3 + j))*8 +: 8] = frame[cur_r-2+i][cur_c-2+j];
    nxt_c = cur_c + 1;
    if (nxt_c == LL) begin nxt_c = 0; nxt_r = cur_r + 1; end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    en = 1'b0; sof = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 6; k++) send_pixel(8'(k + 1), k == 0);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    n_chk++; if (w10 !== '0) begin n_fail++; $display("FAIL reset_window: got %h expected 0", w10); end
    n_chk++; if (v10 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", v10); end
    n_chk++; if (c10 !== '0 || r10 !== '0) begin n_fail++; $display("FAIL reset_pos: got col %0d row %0d expected 0 0", c10, r10); end
    @(negedge clk); rst_n = 1'b1;
    nxt_r = 0; nxt_c = 0;
    @(posedge clk); #1;
    n_chk++; if (w10 !== '0 || v10 !== 1'b0 || c10 !== '0 || r10 !== '0) begin
      n_fail++; $display("FAIL post_reset_hold: got win %h vld %b col %0d row %0d expected all 0", w10, v10, c10, r10);
    end
    send_pixel(8'h5A, 1'b0);
    n_chk++; if (c10 !== 2'd0 || r10 !== 10'd0 || v10 !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_pixel: got col %0d row %0d vld %b expected 0 0 0", c10, r10, v10);
    end
    n_chk++; if (w10[7:0] !== 8'h5A) begin n_fail++; $display("FAIL reset_first_br: got %h expected 5a", w10[7:0]); end
  endtask

  task automatic test_stream(input bit gaps);
    int pulses = 0;
    for (int k = 0; k < 12; k++) begin
      send_pixel(8'(k), k == 0);
      if (v10) pulses++;
      n_chk++; if (v10 !== exp_vld) begin n_fail++; $display("FAIL stream_vld px%0d: got %b expected %b", k, v10, exp_vld); end
      n_chk++; if (c10 !== 2'(cur_c) || r10 !== 10'(cur_r)) begin
        n_fail++; $display("FAIL stream_pos px%0d: got %0d,%0d expected %0d,%0d", k, r10, c10, cur_r, cur_c);
      end
      if (k == 10) begin
        n_chk++; if (w10 !== {8'd0,8'd1,8'd2,8'd4,8'd5,8'd6,8'd8,8'd9,8'd10}) begin
          n_fail++; $display("FAIL stream_win10: got %h", w10);
        end
      end
      if (k == 11) begin
        n_chk++; if (w10 !== {8'd1,8'd2,8'd3,8'd5,8'd6,8'd7,8'd9,8'd10,8'd11}) begin
          n_fail++; $display("FAIL stream_win11: got %h", w10);
        end
      end
      if (gaps) begin
        idle_cycle();
        n_chk++; if (v10 !== 1'b0) begin n_fail++; $display("FAIL gap_vld px%0d: got %b expected 0", k, v10); end
      end
    end
    n_chk++; if (pulses != 2) begin n_fail++; $display("FAIL stream_pulses: got %0d expected 2", pulses); end
  endtask

  task automatic test_sof_restart();
    logic [7:0] v;
    for (int k = 0; k < 12; k++) send_pixel(8'($urandom_range(0, 255)), k == 0);
    send_pixel(8'hAA, 1'b1);
    n_chk++; if (c10 !== 2'd0 || r10 !== 10'd0 || v10 !== 1'b0) begin
      n_fail++; $display("FAIL sof_restart: got col %0d row %0d vld %b expected 0 0 0", c10, r10, v10);
    end
    for (int idx = 2; idx <= 11; idx++) begin
      v = 8'($urandom_range(0, 255));
      send_pixel(v, 1'b0);
      n_chk++; if (v10 !== (idx == 11)) begin n_fail++; $display("FAIL sof_vld px%0d: got %b expected %b", idx, v10, idx == 11); end
      if (idx == 11) begin
        n_chk++; if (w10[7:0] !== v) begin n_fail++; $display("FAIL sof_br: got %h expected %h", w10[7:0], v); end
        n_chk++; if (w10 !== exp_win) begin n_fail++; $display("FAIL sof_win: got %h expected %h", w10, exp_win); end
      end
    end
  endtask

  task automatic test_row_sat();
    int pulses = 0;
    for (int k = 0; k < 6*LL; k++) begin
      send_pixel(8'(8'h10 + k), k == 0);
      if (vs) pulses++;
      n_chk++; if (rs !== sat_row(cur_r) || cs !== 2'(cur_c)) begin
        n_fail++; $display("FAIL sat_pos px%0d: got %0d,%0d expected %0d,%0d", k, rs, cs, sat_row(cur_r), cur_c);
      end
      n_chk++; if (vs !== exp_vld) begin n_fail++; $display("FAIL sat_vld px%0d: got %b expected %b", k, vs, exp_vld); end
      if (exp_vld) begin
        n_chk++; if (ws !== exp_win) begin n_fail++; $display("FAIL sat_win px%0d: got %h expected %h", k, ws, exp_win); end
      end
    end
    n_chk++; if (pulses != 8) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 8", pulses); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int   gap;
      logic s;
      gap = $urandom_range(0, 2);
      s = (n == 0) || ($urandom_range(0, 39) == 0) || (nxt_r >= 60);
      for (int g = 0; g < gap; g++) begin
        idle_cycle();
        n_chk++; if (v10 !== 1'b0 || vs !== 1'b0) begin n_fail++; $display("FAIL rand_idle_vld: got %b/%b expected 0", v10, vs); end
      end
      send_pixel(8'($urandom_range(0, 255)), s);
      n_chk++; if (v10 !== exp_vld || vs !== exp_vld) begin
        n_fail++; $display("FAIL rand_vld n%0d: got %b/%b expected %b", n, v10, vs, exp_vld);
      end
      n_chk++; if (c10 !== 2'(cur_c) || r10 !== 10'(cur_r) || rs !== sat_row(cur_r)) begin
        n_fail++; $display("FAIL rand_pos n%0d: got %0d,%0d expected %0d,%0d", n, r10, c10, cur_r, cur_c);
      end
      if (exp_vld) begin
        n_chk++; if (w10 !== exp_win || ws !== exp_win) begin
          n_fail++; $display("FAIL rand_win n%0d: got %h expected %h", n, w10, exp_win);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    test_reset();
    test_stream(1'b0);
    test_stream(1'b1);
    test_sof_restart();
    test_row_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
